// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if
// Bundles every handshake and bus signal around the shared Booth multiplier:
//   req_*     per-requester valid/ready request channel with operand slices
//   mul_*     start pulse and operands to the datapath, product/done from it
//   rsp_*     single valid/ready response channel (id, product, error flag)
//   err_sticky  watchdog history flag
// Modports:
//   slave   the arbiter side (drives req_ready, mul_*, rsp_*, err_sticky)
//   master  the requester/datapath/consumer side (drives everything else)
interface booth_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;

    logic                 mul_start;
    logic [7:0]           mul_multiplier;
    logic [7:0]           mul_multiplicand;
    logic [15:0]          mul_product;
    logic                 mul_done;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_product;
    logic                 rsp_err;
    logic                 err_sticky;

    modport slave (
        input  req_valid, req_a, req_b, mul_product, mul_done, rsp_ready,
        output req_ready, mul_start, mul_multiplier, mul_multiplicand,
               rsp_valid, rsp_id, rsp_product, rsp_err, err_sticky
    );

    modport master (
        output req_valid, req_a, req_b, mul_product, mul_done, rsp_ready,
        input  req_ready, mul_start, mul_multiplier, mul_multiplicand,
               rsp_valid, rsp_id, rsp_product, rsp_err, err_sticky
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Round-robin arbiter and sequencer sharing one 8x8 Booth multiplier among
// NUM_REQ requesters. One transaction at a time: grant, start pulse, wait for
// the datapath to go busy and come back, then present the product on the
// response channel. A watchdog turns a datapath that never starts or never
// finishes into an error response.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    booth_mul_arbiter_if.slave (request, datapath and response signals)
module booth_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 reset,
    booth_mul_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [7:0]        op_a;
    logic [7:0]        op_b;
    logic [ID_W-1:0]   id_reg;
    logic [CNT_W-1:0]  wd_cnt;
    logic              busy_hits;

    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    scan_sum;
    logic              capture_now;
    logic              abort_now;

    // Round-robin search: the first valid requester at or after rr_ptr wins.
    // scan_sum is one bit wider so rr_ptr+k can wrap with a single subtract.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && bus.req_valid[scan_sum[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[PTR_W-1:0];
            end
        end
    end

    // The accept pulse has to land in the same cycle the request is seen,
    // so it is the only combinational output; it is held off during reset.
    always_comb begin
        bus.req_ready = '0;
        if (reset && state == IDLE && grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // Completion and watchdog decisions. In WAIT_BUSY a done level seen on
    // two consecutive cycles means the datapath never picked up the start.
    always_comb begin
        capture_now = 1'b0;
        abort_now   = 1'b0;
        case (state)
            WAIT_BUSY: abort_now = bus.mul_done && busy_hits;
            WAIT_DONE: begin
                capture_now = bus.mul_done;
                abort_now   = !bus.mul_done && (wd_cnt == CNT_W'(TIMEOUT - 1));
            end
            default: ;
        endcase
    end

    // Operand buses come straight from the op registers, which are only
    // non-zero between the grant and the end of WAIT_DONE.
    assign bus.mul_multiplier   = op_a;
    assign bus.mul_multiplicand = op_b;

    // Main sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            op_a            <= '0;
            op_b            <= '0;
            id_reg          <= '0;
            wd_cnt          <= '0;
            busy_hits       <= 1'b0;
            bus.mul_start   <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_product <= '0;
            bus.rsp_err     <= 1'b0;
            bus.err_sticky  <= 1'b0;
        end else begin
            bus.mul_start <= 1'b0;
            if (capture_now || abort_now) begin
                state           <= RESP;
                bus.rsp_valid   <= 1'b1;
                bus.rsp_id      <= id_reg;
                bus.rsp_product <= capture_now ? bus.mul_product : 16'h0000;
                bus.rsp_err     <= abort_now;
                op_a            <= '0;
                op_b            <= '0;
                if (abort_now) begin
                    bus.err_sticky <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (grant_found) begin
                            op_a          <= bus.req_a[{grant_idx, 3'b000} +: 8];
                            op_b          <= bus.req_b[{grant_idx, 3'b000} +: 8];
                            id_reg        <= ID_W'(grant_idx);
                            rr_ptr        <= (grant_idx == PTR_W'(NUM_REQ - 1)) ?
                                             '0 : grant_idx + 1'b1;
                            bus.mul_start <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        busy_hits <= 1'b0;
                        state     <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (!bus.mul_done) begin
                            wd_cnt <= '0;
                            state  <= WAIT_DONE;
                        end else begin
                            busy_hits <= 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    RESP: begin
                        if (bus.rsp_ready) begin
                            bus.rsp_valid <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
